// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, MSB-first 8-bit frames, single-entry
// TX/RX holding registers with valid/ready handshakes toward the system.
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic       tx_underflow
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_n_s, sck_s, mosi_s, sck_prev_q;
  logic                   sck_rise, sck_fall;

  logic       start, stop, rise_act, fall_act, byte_cmp, reload, shift;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] tx_hold_q, tx_hold_d, rx_hold_q, rx_hold_d;
  logic       tx_full_q, tx_full_d, rx_full_q, rx_full_d;
  logic       miso_q, ovf_q, ovf_d, unf_q, unf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
    end
  end

  assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!cs_n_s) state_d = ACTIVE;
      ACTIVE: if (cs_n_s)  state_d = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    stop     = 1'b0;
    rise_act = 1'b0;
    fall_act = 1'b0;
    case (state_q)
      IDLE:   start = !cs_n_s;
      ACTIVE: begin
        stop     = cs_n_s;
        rise_act = !cs_n_s && sck_rise;
        fall_act = !cs_n_s && sck_fall;
      end
    endcase
  end

  // Shifter reloads at frame start and on the falling edge after each full byte.
  assign byte_cmp = rise_act && (bit_cnt_q == 3'd7);
  assign reload   = start || (fall_act && (bit_cnt_q == 3'd0) && byte_done_q);
  assign shift    = fall_act && (bit_cnt_q != 3'd0);
  assign rx_byte  = {rx_shift_q, mosi_s};

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    byte_done_d = byte_done_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    rx_hold_d   = rx_hold_q;
    rx_full_d   = rx_full_q;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;

    if (start || stop) begin
      bit_cnt_d   = '0;
      rx_shift_d  = '0;
      tx_shift_d  = '0;
      byte_done_d = 1'b0;
    end
    if (rise_act) begin
      rx_shift_d = rx_byte[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (byte_cmp) byte_done_d = 1'b1;
    end
    if (shift) tx_shift_d = {tx_shift_q[6:0], 1'b0};
    if (reload) begin
      if (tx_full_q) begin
        tx_shift_d = tx_hold_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = '0;
        unf_d      = 1'b1;
      end
    end
    // Load needs an empty holding register, consume needs a full one: never both.
    if (tx_valid && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_ready && rx_full_q) rx_full_d = 1'b0;
    if (byte_cmp) begin
      if (rx_full_q && !rx_ready) begin
        ovf_d = 1'b1;
      end else begin
        rx_hold_d = rx_byte;
        rx_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      byte_done_q <= 1'b0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      rx_hold_q   <= '0;
      rx_full_q   <= 1'b0;
      miso_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      byte_done_q <= byte_done_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      rx_hold_q   <= rx_hold_d;
      rx_full_q   <= rx_full_d;
      miso_q      <= tx_shift_q[7];
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = (state_q == ACTIVE);
  assign tx_ready     = ~tx_full_q;
  assign rx_data      = rx_hold_q;
  assign rx_valid     = rx_full_q;
  assign rx_overflow  = ovf_q;
  assign tx_underflow = unf_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: bit-banged mode-0 controller at clk/10, TX feeder and
// RX consumer serviced every falling clk edge, frame-level reference model.
module tb_spi_target;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs_n = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0, rx_overflow, tx_underflow;

  int   tests = 0, fails = 0;
  bq_t  tx_q, rx_got, miso_got;
  int   ovf_hi, ovf_rise, unf_hi, unf_rise, pop_cd = 0;
  logic ovf_prev = 1'b0, unf_prev = 1'b0, oe_seen = 1'b0, rx_auto = 1'b0;

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .tx_underflow(tx_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(255, 0));
  endfunction

  // One clk step: observe pulses/oe, then drive handshakes for the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rx_overflow) ovf_hi++;
    if (rx_overflow && !ovf_prev) ovf_rise++;
    ovf_prev = rx_overflow;
    if (tx_underflow) unf_hi++;
    if (tx_underflow && !unf_prev) unf_rise++;
    unf_prev = tx_underflow;
    if (spi_miso_oe) oe_seen = 1'b1;
    if (pop_cd > 0) begin
      pop_cd--;
      rx_ready = (pop_cd == 0);
    end else begin
      rx_ready = rx_auto;
    end
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (tx_q.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = tx_q[0];
      if (tx_ready) void'(tx_q.pop_front());
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  task automatic clear_mon();
    ovf_hi = 0; ovf_rise = 0; unf_hi = 0; unf_rise = 0; oe_seen = 1'b0;
  endtask

  task automatic preload(input logic [7:0] v);
    tx_q.push_back(v);
    repeat (3) tick();
  endtask

  // Controller side of one byte: MOSI set while SCK low, MISO sampled on SCK rise.
  task automatic spi_byte(input logic [7:0] mo, input int nb, input bit pop_last,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_mosi = mo[i];
      repeat (5) tick();
      spi_sck = 1'b1;
      mi[i] = spi_miso;
      if (pop_last && i == 0) pop_cd = 2;
      repeat (5) tick();
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input bq_t mo, input bq_t late, input int abort_bits,
                           input bit pop_last);
    logic [7:0] got;
    int nb;
    miso_got = {};
    spi_cs_n = 1'b0;
    repeat (6) tick();
    foreach (late[k]) tx_q.push_back(late[k]);
    for (int b = 0; b < mo.size(); b++) begin
      nb = (abort_bits > 0 && b == mo.size() - 1) ? abort_bits : 8;
      spi_byte(mo[b], nb, pop_last && (b == mo.size() - 1), got);
      if (nb == 8) miso_got.push_back(got);
    end
    repeat (6) tick();
    spi_cs_n = 1'b1;
    repeat (6) tick();
  endtask

  // Reload slots: one at frame start plus one after each full byte. Slot 0 can only
  // use the preloaded byte; later slots take bytes queued after start, else 0x00.
  function automatic void model_tx(input bit has_pre, input logic [7:0] pre, input bq_t late,
                                   input int nfull, output bq_t exp_miso, output int exp_unf);
    bq_t src = late;
    logic [7:0] v;
    exp_miso = {};
    exp_unf  = 0;
    for (int k = 0; k <= nfull; k++) begin
      if (k == 0 && has_pre)          v = pre;
      else if (k > 0 && src.size() > 0) v = src.pop_front();
      else begin v = 8'h00; exp_unf++; end
      if (k < nfull) exp_miso.push_back(v);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overflow, tx_underflow} !== 6'b001000) begin
      fails++;
      $display("FAIL reset_outputs: got miso/oe/txr/rxv/ovf/unf=%b want 001000",
               {spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overflow, tx_underflow});
    end
    tests++;
    if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single_byte();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] pre, mo, fill;
      bq_t m, l, ex;
      int eu;
      pre = (it == 0) ? 8'hA5 : rnd8();
      mo  = (it == 0) ? 8'h3C : rnd8();
      fill = rnd8();
      m = {mo}; l = {fill};
      rx_auto = 1'b0;
      preload(pre);
      clear_mon();
      spi_frame(m, l, 0, 1'b0);
      model_tx(1'b1, pre, l, 1, ex, eu);
      tests++;
      if (miso_got[0] !== ex[0]) begin fails++; $display("FAIL single_miso: got %h want %h", miso_got[0], ex[0]); end
      tests++;
      if (rx_valid !== 1'b1 || rx_data !== mo) begin
        fails++; $display("FAIL single_rx: got valid=%b data=%h want 1/%h", rx_valid, rx_data, mo);
      end
      tests++;
      if (unf_rise !== eu || ovf_rise !== 0) begin
        fails++; $display("FAIL single_pulses: got unf=%0d ovf=%0d want %0d/0", unf_rise, ovf_rise, eu);
      end
      rx_got = {};
      rx_auto = 1'b1;
      repeat (3) tick();
      rx_auto = 1'b0;
      tests++;
      if (rx_got.size() !== 1 || rx_got[0] !== mo || rx_valid !== 1'b0) begin
        fails++; $display("FAIL single_drain: got n=%0d %h valid=%b want 1 %h 0", rx_got.size(), rx_got[0], rx_valid, mo);
      end
    end
  endtask

  task automatic test_two_byte();
    for (int it = 0; it < 2; it++) begin
      logic [7:0] pre;
      bq_t m, l, ex;
      int eu;
      pre = (it == 0) ? 8'h12 : rnd8();
      m = (it == 0) ? bq_t'({8'hF0, 8'h0F}) : bq_t'({rnd8(), rnd8()});
      l = (it == 0) ? bq_t'({8'h34, rnd8()}) : bq_t'({rnd8(), rnd8()});
      rx_auto = 1'b1;
      rx_got = {};
      preload(pre);
      clear_mon();
      spi_frame(m, l, 0, 1'b0);
      model_tx(1'b1, pre, l, 2, ex, eu);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (miso_got[k] !== ex[k]) begin fails++; $display("FAIL two_miso%0d: got %h want %h", k, miso_got[k], ex[k]); end
        tests++;
        if (rx_got[k] !== m[k]) begin fails++; $display("FAIL two_rx%0d: got %h want %h", k, rx_got[k], m[k]); end
      end
      tests++;
      if (unf_rise !== eu || ovf_rise !== 0 || rx_got.size() !== 2) begin
        fails++; $display("FAIL two_pulses: got unf=%0d ovf=%0d n=%0d want %0d/0/2", unf_rise, ovf_rise, rx_got.size(), eu);
      end
    end
  endtask

  task automatic test_underflow();
    bq_t m, l, ex;
    int eu;
    m = {rnd8()}; l = {rnd8()};
    rx_auto = 1'b1;
    clear_mon();
    spi_frame(m, l, 0, 1'b0);
    model_tx(1'b0, 8'h00, l, 1, ex, eu);
    tests++;
    if (miso_got[0] !== ex[0]) begin fails++; $display("FAIL unf_miso: got %h want %h", miso_got[0], ex[0]); end
    tests++;
    if (unf_rise !== eu || unf_hi !== eu) begin
      fails++; $display("FAIL unf_pulse: got pulses=%0d high_cycles=%0d want %0d/%0d", unf_rise, unf_hi, eu, eu);
    end
    tests++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL unf_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_overflow();
    bq_t m, l;
    logic [7:0] pre;
    for (int pop = 0; pop < 2; pop++) begin
      pre = rnd8();
      m = {8'h11, 8'h22};
      l = {rnd8(), rnd8()};
      rx_auto = 1'b0;
      rx_got = {};
      preload(pre);
      clear_mon();
      spi_frame(m, l, 0, pop == 1);
      tests++;
      if (rx_valid !== 1'b1 || rx_data !== m[pop]) begin
        fails++; $display("FAIL ovf%0d_rx: got valid=%b data=%h want 1/%h", pop, rx_valid, rx_data, m[pop]);
      end
      tests++;
      if (ovf_rise !== 1 - pop || ovf_hi !== 1 - pop) begin
        fails++; $display("FAIL ovf%0d_pulse: got pulses=%0d high_cycles=%0d want %0d", pop, ovf_rise, ovf_hi, 1 - pop);
      end
      rx_auto = 1'b1;
      repeat (3) tick();
      tests++;
      if (rx_got.size() !== pop + 1 || rx_got[0] !== 8'h11 || rx_got[pop] !== m[pop]) begin
        fails++; $display("FAIL ovf%0d_drain: got n=%0d %h %h want %0d 11 %h", pop, rx_got.size(), rx_got[0], rx_got[pop], pop + 1, m[pop]);
      end
    end
  endtask

  task automatic test_abort();
    bq_t m, l, ex;
    int eu;
    logic [7:0] pre;
    rx_auto = 1'b1;
    rx_got = {};
    pre = rnd8();
    preload(pre);
    clear_mon();
    m = {rnd8()}; l = {};
    spi_frame(m, l, 5, 1'b0);
    model_tx(1'b1, pre, l, 0, ex, eu);
    tests++;
    if (rx_got.size() !== 0 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL abort_rx: got n=%0d valid=%b want 0/0", rx_got.size(), rx_valid);
    end
    tests++;
    if (oe_seen !== 1'b1 || spi_miso_oe !== 1'b0) begin
      fails++; $display("FAIL abort_oe: got seen=%b idle=%b want 1/0", oe_seen, spi_miso_oe);
    end
    tests++;
    if (unf_rise !== eu) begin fails++; $display("FAIL abort_unf: got %0d want %0d", unf_rise, eu); end
    pre = rnd8();
    preload(pre);
    m = {8'h81}; l = {rnd8()};
    spi_frame(m, l, 0, 1'b0);
    model_tx(1'b1, pre, l, 1, ex, eu);
    tests++;
    if (rx_got.size() !== 1 || rx_got[0] !== 8'h81 || miso_got[0] !== ex[0]) begin
      fails++; $display("FAIL abort_next: got n=%0d rx=%h miso=%h want 1 81 %h", rx_got.size(), rx_got[0], miso_got[0], ex[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pre, dummy;
    bq_t m, l, ex;
    int eu;
    rx_auto = 1'b1;
    preload(rnd8());
    spi_cs_n = 1'b0;
    repeat (6) tick();
    tx_q.push_back(rnd8());
    spi_byte(rnd8(), 4, 1'b0, dummy);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overflow, tx_underflow} !== 6'b001000) begin
      fails++;
      $display("FAIL midrst_outputs: got miso/oe/txr/rxv/ovf/unf=%b want 001000",
               {spi_miso, spi_miso_oe, tx_ready, rx_valid, rx_overflow, tx_underflow});
    end
    tests++;
    if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx_data: got %h want 00", rx_data); end
    repeat (3) tick();
    clear_mon();
    rst_n = 1'b1;
    repeat (6) tick();
    tests++;
    if (spi_miso_oe !== 1'b1 || unf_rise !== 1) begin
      fails++; $display("FAIL midrst_restart: got oe=%b unf=%0d want 1/1", spi_miso_oe, unf_rise);
    end
    spi_cs_n = 1'b1;
    repeat (6) tick();
    rx_got = {};
    pre = rnd8();
    preload(pre);
    m = {rnd8()}; l = {rnd8()};
    spi_frame(m, l, 0, 1'b0);
    model_tx(1'b1, pre, l, 1, ex, eu);
    tests++;
    if (miso_got[0] !== ex[0] || rx_got.size() !== 1 || rx_got[0] !== m[0]) begin
      fails++; $display("FAIL midrst_frame: got miso=%h rx=%h n=%0d want %h %h 1", miso_got[0], rx_got[0], rx_got.size(), ex[0], m[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      bq_t m, l, ex;
      int eu, nb;
      bit has_pre;
      logic [7:0] pre;
      nb = $urandom_range(3, 1);
      has_pre = 1'($urandom_range(1, 0));
      pre = rnd8();
      m = {}; l = {};
      for (int k = 0; k < nb; k++) begin m.push_back(rnd8()); l.push_back(rnd8()); end
      rx_auto = 1'b1;
      rx_got = {};
      if (has_pre) preload(pre);
      clear_mon();
      spi_frame(m, l, 0, 1'b0);
      model_tx(has_pre, pre, l, nb, ex, eu);
      for (int k = 0; k < nb; k++) begin
        tests++;
        if (miso_got[k] !== ex[k] || rx_got[k] !== m[k]) begin
          fails++; $display("FAIL rand%0d_byte%0d: got miso=%h rx=%h want %h %h", it, k, miso_got[k], rx_got[k], ex[k], m[k]);
        end
      end
      tests++;
      if (unf_rise !== eu || ovf_rise !== 0 || rx_got.size() !== nb) begin
        fails++; $display("FAIL rand%0d_pulses: got unf=%0d ovf=%0d n=%0d want %0d/0/%0d", it, unf_rise, ovf_rise, rx_got.size(), eu, nb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_byte();
    test_underflow();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
